// File: rtl/conv_window_gen_pkg.sv
// Shared constants for the convolution datapath.
// CONV_MULT_WIDTH : multiplier operand (pixel) width.
// MA_TREE_SIZE    : lane count of the multiply-add tree (power of 2).
// MA_TREE_LATENCY : fixed tree latency, one multiply stage plus one stage per adder level.
package conv_window_gen_pkg;

  localparam int CONV_MULT_WIDTH = 8;
  localparam int MA_TREE_SIZE    = 16;

  function automatic int ma_latency(input int tree_size);
    return 1 + $clog2(tree_size);
  endfunction

  localparam int MA_TREE_LATENCY = ma_latency(MA_TREE_SIZE);

endpackage

// File: rtl/conv_line_buffer.sv
// One row delay line: a DEPTH-stage, WIDTH-bit shift register that advances only when en=1.
// dout is the sample shifted in DEPTH enabled cycles ago.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset, clears every stage
//   en     shift enable (one accepted pixel)
//   din    sample entering the line
//   dout   sample leaving the line
module conv_line_buffer #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Producer for the convolution multiply-add tree. Takes a raster-order pixel stream, keeps
// KERNEL_SIZE-1 row delay lines and presents a registered KxK window packed onto the tree's
// operand lanes (lane r*K+c, r=0 oldest row, c=0 oldest column, lanes >= K*K are zero).
// A valid/coordinate pipe matched to the tree latency marks when the tree's sum is ready.
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   frame_restart  next accepted pixel (or one accepted this cycle) is (0,0)
//   pix_in         pixel data
//   pix_valid      pixel accepted this cycle (no backpressure)
//   window_out     packed window to tree operand vector
//   window_valid   1-cycle pulse: window_out is a complete in-frame window
//   frame_done     pulses with window_valid for the last pixel of the frame
//   sum_valid      window_valid delayed MA_LATENCY cycles
//   sum_row        output row of the window whose sum is now leaving the tree
//   sum_col        output column, same alignment
// Handshake: there is no ready; every cycle with pix_valid=1 consumes pix_in, and every
// output valid is a single-cycle pulse the consumer must take in that cycle.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int IMG_WIDTH   = 5,
  parameter int IMG_HEIGHT  = 5,
  parameter int KERNEL_SIZE = 3,
  parameter int PIX_WIDTH   = CONV_MULT_WIDTH,
  parameter int TREE_SIZE   = MA_TREE_SIZE,
  parameter int MA_LATENCY  = MA_TREE_LATENCY
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              frame_restart,
  input  logic [PIX_WIDTH-1:0]              pix_in,
  input  logic                              pix_valid,
  output logic [PIX_WIDTH*TREE_SIZE-1:0]    window_out,
  output logic                              window_valid,
  output logic                              frame_done,
  output logic                              sum_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0]     sum_row,
  output logic [$clog2(IMG_WIDTH)-1:0]      sum_col
);

  localparam int K  = KERNEL_SIZE;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int L  = MA_LATENCY;

  if (K * K > TREE_SIZE) begin : g_bad_kernel
    $error("conv_window_gen: KERNEL_SIZE*KERNEL_SIZE exceeds TREE_SIZE");
  end
  if (K < 2 || L < 2) begin : g_bad_depth
    $error("conv_window_gen: KERNEL_SIZE and MA_LATENCY must be at least 2");
  end

  // ---------------- position counters ----------------
  logic [RW-1:0] row_q, cur_row;
  logic [CW-1:0] col_q, cur_col;
  logic          last_row, last_col, in_window;

  // A restart forces the pixel taken this cycle to be (0,0).
  always_comb begin
    cur_row   = frame_restart ? '0 : row_q;
    cur_col   = frame_restart ? '0 : col_q;
    last_row  = (cur_row == RW'(IMG_HEIGHT - 1));
    last_col  = (cur_col == CW'(IMG_WIDTH - 1));
    // Columns < K-1 straddle the row wrap and rows < K-1 still hold the previous frame.
    in_window = (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
  end

  // ---------------- row delay lines ----------------
  logic [PIX_WIDTH-1:0] lb_in  [K-1];
  logic [PIX_WIDTH-1:0] lb_out [K-1];
  logic [PIX_WIDTH-1:0] col_in [K];

  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    if (g == 0) begin : g_first
      assign lb_in[g] = pix_in;
    end else begin : g_chain
      assign lb_in[g] = lb_out[g-1];
    end
    conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_WIDTH)) u_lb (
      .clock (clock),
      .reset (reset),
      .en    (pix_valid),
      .din   (lb_in[g]),
      .dout  (lb_out[g])
    );
  end

  // New right-hand column, top (oldest) row comes from the deepest line.
  for (genvar r = 0; r < K; r++) begin : g_col
    if (r == K - 1) begin : g_new
      assign col_in[r] = pix_in;
    end else begin : g_old
      assign col_in[r] = lb_out[K-2-r];
    end
  end

  // ---------------- window registers ----------------
  logic [PIX_WIDTH-1:0] win [K][K];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (pix_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= col_in[r];
      end
    end
  end

  always_comb begin
    window_out = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        window_out[PIX_WIDTH*(r*K+c) +: PIX_WIDTH] = win[r][c];
  end

  // ---------------- counters, window strobes ----------------
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q        <= '0;
      col_q        <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
    end else begin
      window_valid <= pix_valid && in_window;
      frame_done   <= pix_valid && last_row && last_col;
      if (pix_valid) begin
        col_q <= last_col ? '0 : cur_col + CW'(1);
        if (last_col) row_q <= last_row ? '0 : cur_row + RW'(1);
        else          row_q <= cur_row;
      end else if (frame_restart) begin
        row_q <= '0;
        col_q <= '0;
      end
      if (pix_valid && in_window) begin
        win_row <= cur_row - RW'(K - 1);
        win_col <= cur_col - CW'(K - 1);
      end
    end
  end

  // ---------------- valid / coordinate pipe ----------------
  // The last stage only loads on a valid arrival so sum_row/sum_col hold between pulses.
  logic [L-1:0]  v_pipe;
  logic [RW-1:0] r_pipe [L];
  logic [CW-1:0] c_pipe [L];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_pipe <= '0;
      for (int i = 0; i < L; i++) begin
        r_pipe[i] <= '0;
        c_pipe[i] <= '0;
      end
    end else begin
      v_pipe    <= {v_pipe[L-2:0], window_valid};
      r_pipe[0] <= win_row;
      c_pipe[0] <= win_col;
      for (int i = 1; i < L - 1; i++) begin
        r_pipe[i] <= r_pipe[i-1];
        c_pipe[i] <= c_pipe[i-1];
      end
      if (v_pipe[L-2]) begin
        r_pipe[L-1] <= r_pipe[L-2];
        c_pipe[L-1] <= c_pipe[L-2];
      end
    end
  end

  assign sum_valid = v_pipe[L-1];
  assign sum_row   = r_pipe[L-1];
  assign sum_col   = c_pipe[L-1];

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen (W=H=5, K=3, 8-bit pixels, 16 lanes, latency 5).
module tb_conv_window_gen;

  localparam int W   = 5;
  localparam int H   = 5;
  localparam int K   = 3;
  localparam int PW  = 8;
  localparam int TS  = 16;
  localparam int LAT = 5;
  localparam int OW  = PW * TS;
  localparam int XW  = OW + 1;

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          frame_restart = 1'b0;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] pix_in = '0;
  logic [OW-1:0] window_out;
  logic          window_valid, frame_done, sum_valid;
  logic [2:0]    sum_row, sum_col;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  conv_window_gen #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K),
    .PIX_WIDTH(PW), .TREE_SIZE(TS), .MA_LATENCY(LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .frame_restart (frame_restart),
    .pix_in        (pix_in),
    .pix_valid     (pix_valid),
    .window_out    (window_out),
    .window_valid  (window_valid),
    .frame_done    (frame_done),
    .sum_valid     (sum_valid),
    .sum_row       (sum_row),
    .sum_col       (sum_col)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [OW:0]   exp_q[$];      // {frame_done, window}
  int            exp_at_q[$];
  logic [5:0]    sum_q[$];      // {row, col}
  int            sum_at_q[$];
  logic [OW-1:0] win_log[$];
  logic [5:0]    sum_log[$];
  int            fd_count = 0;

  logic [PW-1:0] grid [H][W];
  int mr = 0;
  int mc = 0;

  task automatic check(input string name, input logic [OW:0] act, input logic [OW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] lane_vec(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    int v[9];
    logic [OW-1:0] res;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    res = '0;
    for (int i = 0; i < 9; i++) res[PW*i +: PW] = PW'(v[i]);
    return res;
  endfunction

  function automatic logic [OW-1:0] win_from_grid(input int r, input int c);
    logic [OW-1:0] res;
    res = '0;
    for (int rr = 0; rr < K; rr++)
      for (int cc = 0; cc < K; cc++)
        res[PW*(rr*K+cc) +: PW] = grid[r-K+1+rr][c-K+1+cc];
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [PW-1:0] p, input logic restart);
    pix_in = p;
    pix_valid = 1'b1;
    frame_restart = restart;
    if (restart) begin
      mr = 0;
      mc = 0;
    end
    grid[mr][mc] = p;
    if (mr >= K - 1 && mc >= K - 1) begin
      exp_q.push_back({(mr == H - 1 && mc == W - 1), win_from_grid(mr, mc)});
      exp_at_q.push_back(cyc + 1);
      sum_q.push_back({3'(mr - K + 1), 3'(mc - K + 1)});
      sum_at_q.push_back(cyc + 1 + LAT);
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
    @(posedge clock);
    #1;
    pix_valid = 1'b0;
    frame_restart = 1'b0;
    pix_in = '0;
  endtask

  task automatic send_frame(input int base, input bit toggle);
    for (int i = 0; i < W * H; i++) begin
      send(PW'(base + i), 1'b0);
      if (toggle) idle(1);
    end
  endtask

  task automatic drain();
    int budget = 200;
    while ((exp_q.size() != 0 || sum_q.size() != 0) && budget > 0) begin
      idle(1);
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0 || sum_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d windows and %0d sums still pending", exp_q.size(), sum_q.size());
      exp_q.delete(); exp_at_q.delete(); sum_q.delete(); sum_at_q.delete();
    end
    idle(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wvalid"}, XW'(window_valid), XW'(0));
    check({tag, "_wout"},   XW'(window_out),   XW'(0));
    check({tag, "_fdone"},  XW'(frame_done),   XW'(0));
    check({tag, "_svalid"}, XW'(sum_valid),    XW'(0));
    check({tag, "_srow"},   XW'(sum_row),      XW'(0));
    check({tag, "_scol"},   XW'(sum_col),      XW'(0));
  endtask

  task automatic clear_logs();
    win_log.delete();
    sum_log.delete();
    fd_count = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (frame_done) fd_count++;
      if (window_valid) begin
        win_log.push_back(window_out);
        if (exp_q.size() == 0) begin
          check("win_unexpected", XW'(window_valid), XW'(0));
        end else begin
          check("window", {frame_done, window_out}, exp_q.pop_front());
          check("win_cycle", XW'(cyc), XW'(exp_at_q.pop_front()));
        end
      end else begin
        if (frame_done) check("fdone_alone", XW'(frame_done), XW'(0));
      end
      if (sum_valid) begin
        sum_log.push_back({sum_row, sum_col});
        if (sum_q.size() == 0) begin
          check("sum_unexpected", XW'(sum_valid), XW'(0));
        end else begin
          check("sum_coord", XW'({sum_row, sum_col}), XW'(sum_q.pop_front()));
          check("sum_cycle", XW'(cyc), XW'(sum_at_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle(2);
    check_outputs_zero("rst");
    reset = 1'b1;
    idle(1);

    // Test 1 + row wrap: one back-to-back frame.
    clear_logs();
    send_frame(0, 1'b0);
    drain();
    check("t1_count", XW'(win_log.size()), XW'(9));
    check("t1_first", XW'(win_log[0]), XW'(lane_vec(0, 1, 2, 5, 6, 7, 10, 11, 12)));
    check("t3_pix17", XW'(win_log[3]), XW'(lane_vec(5, 6, 7, 10, 11, 12, 15, 16, 17)));
    check("t1_sum0", XW'(sum_log[0]), XW'({3'd0, 3'd0}));
    check("t1_sum4", XW'(sum_log[4]), XW'({3'd1, 3'd1}));
    check("t1_sum8", XW'(sum_log[8]), XW'({3'd2, 3'd2}));
    check("t1_fdone", XW'(fd_count), XW'(1));
    check("hold_svalid", XW'(sum_valid), XW'(0));
    check("hold_coord", XW'({sum_row, sum_col}), XW'({3'd2, 3'd2}));

    // Test 2: same frame with pix_valid toggled.
    clear_logs();
    send_frame(0, 1'b1);
    drain();
    check("t2_count", XW'(win_log.size()), XW'(9));
    check("t2_first", XW'(win_log[0]), XW'(lane_vec(0, 1, 2, 5, 6, 7, 10, 11, 12)));
    check("t2_last", XW'(win_log[8]), XW'(lane_vec(12, 13, 14, 17, 18, 19, 22, 23, 24)));

    // Test 4: two frames back-to-back.
    clear_logs();
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    drain();
    check("t4_fdone", XW'(fd_count), XW'(2));
    check("t4_count", XW'(win_log.size()), XW'(18));
    check("t4_f2first", XW'(win_log[9]),
          XW'(lane_vec(100, 101, 102, 105, 106, 107, 110, 111, 112)));

    // Test 5: reset mid-frame after pixel 13.
    clear_logs();
    for (int i = 0; i <= 13; i++) send(PW'(i), 1'b0);
    reset = 1'b0;
    #1;
    check_outputs_zero("midrst");
    exp_q.delete(); exp_at_q.delete(); sum_q.delete(); sum_at_q.delete();
    mr = 0;
    mc = 0;
    idle(3);
    reset = 1'b1;
    idle(1);
    clear_logs();
    send_frame(0, 1'b0);
    drain();
    check("t5_count", XW'(win_log.size()), XW'(9));
    check("t5_first", XW'(win_log[0]), XW'(lane_vec(0, 1, 2, 5, 6, 7, 10, 11, 12)));

    // Test 6: restart at pixel 7 while the previous frame's sums are still in flight.
    clear_logs();
    send_frame(0, 1'b0);
    for (int i = 0; i < 7; i++) send(PW'(i), 1'b0);
    send(PW'(50), 1'b1);
    for (int i = 1; i < W * H; i++) send(PW'(50 + i), 1'b0);
    drain();
    check("t6_count", XW'(win_log.size()), XW'(18));
    check("t6_sums", XW'(sum_log.size()), XW'(18));
    check("t6_first", XW'(win_log[9]), XW'(lane_vec(50, 51, 52, 55, 56, 57, 60, 61, 62)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
